// File: rtl/tick_period_meter.sv
// Tick period meter: counts clk cycles between rising edges of tick_in.
// Lock tracking is built only when TICK_PERIOD_METER_LOCK_EN is defined.
module tick_period_meter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             tick_in,
  input  logic             ack,
  output logic [WIDTH-1:0] period,
  output logic             valid,
  output logic             ovf,
  output logic             lost,
  output logic             locked
);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_e;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic             tick_q;
  logic             tick_edge;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             capture;

  logic [WIDTH-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             lost_q, lost_d;
  logic             locked_q, locked_d;
  logic             lock_new;

  logic             do_load;
  logic             do_drop;
  logic             do_clr;

  assign tick_edge = tick_in & ~tick_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        sat_d = 1'b0;
        if (en && tick_edge) begin
          state_d = MEASURE;
          cnt_d   = CNT_ONE;
        end
      end
      MEASURE: begin
        if (!en) begin
          state_d = IDLE;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end else if (tick_edge) begin
          capture = 1'b1;
          cnt_d   = CNT_ONE;
          sat_d   = 1'b0;
        end else if (cnt_q == CNT_MAX) begin
          sat_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
    endcase
  end

`ifdef TICK_PERIOD_METER_LOCK_EN
  logic [WIDTH-1:0] prev_q;
  logic             prev_ok_q;
  logic             leave_meas;

  assign leave_meas = (state_q == MEASURE) & ~en;
  assign lock_new   = prev_ok_q & ~sat_q & (prev_q == cnt_q);

  // Dropped captures still train the lock history.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q    <= '0;
      prev_ok_q <= 1'b0;
    end else if (capture) begin
      prev_q    <= cnt_q;
      prev_ok_q <= ~sat_q;
    end else if (leave_meas) begin
      prev_ok_q <= 1'b0;
    end
  end
`else
  assign lock_new = 1'b0;
`endif

  assign do_load = capture & (~valid_q | ack);
  assign do_drop = capture & valid_q & ~ack;
  assign do_clr  = ~capture & valid_q & ack;

  // cnt_q already sits at all-ones once sat_q is set.
  always_comb begin
    period_d = period_q;
    valid_d  = valid_q;
    ovf_d    = ovf_q;
    lost_d   = lost_q;
    locked_d = locked_q;
    unique case (1'b1)
      do_load: begin
        period_d = cnt_q;
        ovf_d    = sat_q;
        locked_d = lock_new;
        valid_d  = 1'b1;
        if (valid_q) begin
          lost_d = 1'b0;
        end
      end
      do_drop: begin
        lost_d = 1'b1;
      end
      do_clr: begin
        valid_d = 1'b0;
        lost_d  = 1'b0;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      period_q <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      lost_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      period_q <= period_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      lost_q   <= lost_d;
      locked_q <= locked_d;
    end
  end

  assign period = period_q;
  assign valid  = valid_q;
  assign ovf    = ovf_q;
  assign lost   = lost_q;
  assign locked = locked_q;

endmodule

// File: tb/tb_tick_period_meter.sv
// Bench for tick_period_meter: timestamp-based reference model
// checked every cycle, plus directed literal checks.
module tb_tick_period_meter;

  localparam int W = 8;
  localparam int MAXP = (1 << W) - 1;
`ifdef TICK_PERIOD_METER_LOCK_EN
  localparam int LOCK = 1;
`else
  localparam int LOCK = 0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         tick_in;
  logic         ack;
  logic [W-1:0] period;
  logic         valid;
  logic         ovf;
  logic         lost;
  logic         locked;

  int n_cmp = 0;
  int n_bad = 0;

  tick_period_meter #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .tick_in(tick_in),
    .ack    (ack),
    .period (period),
    .valid  (valid),
    .ovf    (ovf),
    .lost   (lost),
    .locked (locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)",
               nm, got, exp, $time);
    end
  endtask

  // Reference model: periods from edge timestamps, not counters.
  int cyc = 0;
  int t0 = 0;
  bit armed = 0;
  bit m_tq = 0;
  bit m_init = 0;
  int m_period = 0;
  bit m_valid = 0;
  bit m_ovf = 0;
  bit m_lost = 0;
  bit m_locked = 0;
  int prev = 0;
  bit prev_ok = 0;

  always @(posedge clk) begin
    automatic bit e = tick_in & ~m_tq;
    automatic bit cap = 0;
    automatic int p = 0;
    automatic bit po;
    automatic int pv;
    automatic bit lk;
    automatic int a_t0 = t0;
    automatic bit a_arm = armed;
    automatic bit a_pok = prev_ok;
    automatic int a_prev = prev;
    automatic int a_per = m_period;
    automatic bit a_val = m_valid;
    automatic bit a_ovf = m_ovf;
    automatic bit a_lost = m_lost;
    automatic bit a_lk = m_locked;
    cyc <= cyc + 1;
    if (rst) begin
      m_tq <= 0;
      m_init <= 1;
      a_arm = 0; a_pok = 0; a_prev = 0; a_t0 = 0;
      a_per = 0; a_val = 0; a_ovf = 0; a_lost = 0; a_lk = 0;
    end else begin
      m_tq <= tick_in;
      if (!en) begin
        a_arm = 0;
        a_pok = 0;
      end else if (e) begin
        if (a_arm) begin
          cap = 1;
          p = cyc - a_t0;
        end
        a_arm = 1;
        a_t0 = cyc;
      end
      if (cap) begin
        po = p > MAXP;
        pv = po ? MAXP : p;
        lk = (LOCK != 0) && a_pok && !po && (a_prev == pv);
        if (!a_val || ack) begin
          if (a_val) a_lost = 0;
          a_per = pv; a_ovf = po; a_lk = lk; a_val = 1;
        end else begin
          a_lost = 1;
        end
        a_prev = pv;
        a_pok = !po;
      end else if (ack && a_val) begin
        a_val = 0;
        a_lost = 0;
      end
    end
    t0 <= a_t0; armed <= a_arm; prev_ok <= a_pok; prev <= a_prev;
    m_period <= a_per; m_valid <= a_val; m_ovf <= a_ovf;
    m_lost <= a_lost; m_locked <= a_lk;
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("m.period", int'(period), m_period);
      chk("m.valid", int'(valid), int'(m_valid));
      chk("m.ovf", int'(ovf), int'(m_ovf));
      chk("m.lost", int'(lost), int'(m_lost));
      chk("m.locked", int'(locked), int'(m_locked));
    end
  end

  task automatic cy(input bit t);
    tick_in = t;
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    repeat (n) cy(1'b0);
  endtask

  initial begin
    rst = 1; en = 0; tick_in = 0; ack = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.period", int'(period), 0);
    chk("rst.valid", int'(valid), 0);
    chk("rst.ovf", int'(ovf), 0);
    chk("rst.lost", int'(lost), 0);
    chk("rst.locked", int'(locked), 0);

    // prescaler source, ack held high
    rst = 0; en = 1; ack = 1;
    cy(1);
    chk("first.valid", int'(valid), 0);
    gap(128); cy(1);
    chk("p129.period", int'(period), 129);
    chk("p129.ovf", int'(ovf), 0);
    chk("p129.valid", int'(valid), 1);
    gap(128); cy(1);
    chk("p129.locked", int'(locked), LOCK);

    // saturation boundary
    gap(254); cy(1);
    chk("p255.period", int'(period), 255);
    chk("p255.ovf", int'(ovf), 0);
    gap(299); cy(1);
    chk("p300.period", int'(period), 255);
    chk("p300.ovf", int'(ovf), 1);
    chk("p300.locked", int'(locked), 0);

    // handshake and loss
    gap(1); ack = 0;
    gap(8); cy(1);
    chk("h10.period", int'(period), 10);
    gap(11); cy(1);
    chk("h12.period", int'(period), 10);
    chk("h12.valid", int'(valid), 1);
    chk("h12.lost", int'(lost), 1);
    ack = 1; gap(1); ack = 0;
    chk("hack.valid", int'(valid), 0);
    chk("hack.lost", int'(lost), 0);

    // simultaneous ack and capture
    gap(8); cy(1);
    chk("s10.period", int'(period), 10);
    gap(13); ack = 1; cy(1); ack = 0;
    chk("s14.period", int'(period), 14);
    chk("s14.valid", int'(valid), 1);
    chk("s14.lost", int'(lost), 0);

    // level input; first rise is the minimum period
    ack = 1; gap(1);
    for (int k = 0; k < 3; k++) begin
      cy(1);
      chk($sformatf("lvl%0d.period", k), int'(period), (k == 0) ? 2 : 20);
      repeat (4) cy(1);
      gap(15);
    end
    en = 0; gap(5); cy(1);
    en = 1; repeat (3) cy(1);
    chk("en.valid0", int'(valid), 0);
    gap(10); cy(1);
    chk("en.edge1", int'(valid), 0);
    repeat (4) cy(1);
    gap(15); cy(1);
    chk("en.period", int'(period), 20);
    chk("en.valid", int'(valid), 1);

    // reset mid-measurement with a result pending
    ack = 0;
    repeat (4) cy(1);
    gap(45);
    rst = 1; cy(0); rst = 0;
    chk("mrst.period", int'(period), 0);
    chk("mrst.valid", int'(valid), 0);
    chk("mrst.lost", int'(lost), 0);
    gap(10); cy(1);
    chk("mrst.edge1", int'(valid), 0);
    gap(14); cy(1);
    chk("mrst.period15", int'(period), 15);
    chk("mrst.valid15", int'(valid), 1);
    gap(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
